// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter: round-robin arbiter sharing one smart_ram port between NUM_REQ
// effect blocks. One whole transaction (request -> finish) is granted at a time.
// Optional watchdog: define SRAM_ARB_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES cycles without the matching finish.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_wr/req_rd/req_data/req_offset   per-requester master interface (packed)
//   req_write_finish/req_read_finish    1-cycle done pulses to the granted requester
//   req_data_out                  shared read data, updated on read completion
//   grant, busy, err_timeout      status
//   sram_*                        smart_ram side
module sram_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ-1:0]            req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_offset,
  output logic [NUM_REQ-1:0]            req_write_finish,
  output logic [NUM_REQ-1:0]            req_read_finish,
  output logic [DATA_WIDTH-1:0]         req_data_out,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          err_timeout,
  output logic                          sram_wr,
  output logic                          sram_rd,
  output logic [DATA_WIDTH-1:0]         sram_data_in,
  output logic [ADDR_WIDTH-1:0]         sram_offset,
  input  logic [DATA_WIDTH-1:0]         sram_data_out,
  input  logic                          sram_read_finish,
  input  logic                          sram_write_finish,
  input  logic                          sram_available
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time guard on the supported parameter range.
  if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sram_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RELEASE} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        last_grant, last_grant_nxt;
  logic [IDX_W-1:0]        cur_idx, cur_idx_nxt;
  logic                    op_wr, op_wr_nxt;
  logic [NUM_REQ-1:0]      req_any;
  logic                    sel_valid;
  logic [IDX_W-1:0]        sel_idx;
  logic                    fin_c;

  logic [NUM_REQ-1:0]      wfin_nxt, rfin_nxt, grant_nxt;
  logic [DATA_WIDTH-1:0]   data_out_nxt, data_in_nxt;
  logic [ADDR_WIDTH-1:0]   offset_nxt;
  logic                    busy_nxt, err_nxt, sram_wr_nxt, sram_rd_nxt;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        cnt, cnt_nxt;
`endif

  assign req_any = req_wr | req_rd;

  // Round-robin pick: first requester after last_grant. Scanning downwards
  // lets the closest candidate overwrite farther ones.
  always_comb begin
    int idx;
    sel_valid = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (req_any[IDX_W'(idx)]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(idx);
      end
    end
  end

  // Only the finish matching the latched operation completes the access.
  assign fin_c = op_wr ? sram_write_finish : sram_read_finish;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cur_idx_nxt    = cur_idx;
    op_wr_nxt      = op_wr;
    wfin_nxt       = '0;
    rfin_nxt       = '0;
    grant_nxt      = grant;
    data_out_nxt   = req_data_out;
    data_in_nxt    = sram_data_in;
    offset_nxt     = sram_offset;
    busy_nxt       = busy;
    err_nxt        = 1'b0;
    sram_wr_nxt    = sram_wr;
    sram_rd_nxt    = sram_rd;
`ifdef SRAM_ARB_TIMEOUT_EN
    cnt_nxt        = cnt;
`endif
    case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (sel_valid && sram_available) begin
          state_nxt   = ST_ACCESS;
          cur_idx_nxt = sel_idx;
          op_wr_nxt   = req_wr[sel_idx];
          sram_wr_nxt = req_wr[sel_idx];
          sram_rd_nxt = ~req_wr[sel_idx];
          data_in_nxt = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
          offset_nxt  = req_offset[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
          grant_nxt   = NUM_REQ'(1'b1) << sel_idx;
          busy_nxt    = 1'b1;
`ifdef SRAM_ARB_TIMEOUT_EN
          cnt_nxt     = '0;
`endif
        end
      end
      ST_ACCESS: begin
        if (fin_c) begin
          wfin_nxt[cur_idx] = op_wr;
          rfin_nxt[cur_idx] = ~op_wr;
          if (!op_wr) data_out_nxt = sram_data_out;
          sram_wr_nxt    = 1'b0;
          sram_rd_nxt    = 1'b0;
          last_grant_nxt = cur_idx;
          state_nxt      = ST_RELEASE;
        end
`ifdef SRAM_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort: no finish pulse to the requester, only the error flag.
          err_nxt        = 1'b1;
          sram_wr_nxt    = 1'b0;
          sram_rd_nxt    = 1'b0;
          last_grant_nxt = cur_idx;
          state_nxt      = ST_RELEASE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      ST_RELEASE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        grant_nxt   = '0;
        busy_nxt    = 1'b0;
        sram_wr_nxt = 1'b0;
        sram_rd_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      last_grant       <= IDX_W'(NUM_REQ - 1);
      cur_idx          <= '0;
      op_wr            <= 1'b0;
      req_write_finish <= '0;
      req_read_finish  <= '0;
      req_data_out     <= '0;
      grant            <= '0;
      busy             <= 1'b0;
      err_timeout      <= 1'b0;
      sram_wr          <= 1'b0;
      sram_rd          <= 1'b0;
      sram_data_in     <= '0;
      sram_offset      <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      cnt              <= '0;
`endif
    end else begin
      state            <= state_nxt;
      last_grant       <= last_grant_nxt;
      cur_idx          <= cur_idx_nxt;
      op_wr            <= op_wr_nxt;
      req_write_finish <= wfin_nxt;
      req_read_finish  <= rfin_nxt;
      req_data_out     <= data_out_nxt;
      grant            <= grant_nxt;
      busy             <= busy_nxt;
      err_timeout      <= err_nxt;
      sram_wr          <= sram_wr_nxt;
      sram_rd          <= sram_rd_nxt;
      sram_data_in     <= data_in_nxt;
      sram_offset      <= offset_nxt;
`ifdef SRAM_ARB_TIMEOUT_EN
      cnt              <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for sram_arbiter with a small smart_ram model and a
// scoreboard of expected finish pulses.
module tb_sram_arbiter;

  localparam int NR = 2;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int TO = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_wr = '0, req_rd = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*AW-1:0] req_offset = '0;
  logic [NR-1:0]    req_write_finish, req_read_finish, grant;
  logic [DW-1:0]    req_data_out, sram_data_in;
  logic [AW-1:0]    sram_offset;
  logic             busy, err_timeout, sram_wr, sram_rd;
  logic             sram_available = 1'b1;
  logic             sram_read_finish, sram_write_finish;
  logic [DW-1:0]    sram_data_out;

  always #5 clk = ~clk;

  sram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_wr(req_wr), .req_rd(req_rd), .req_data(req_data), .req_offset(req_offset),
    .req_write_finish(req_write_finish), .req_read_finish(req_read_finish),
    .req_data_out(req_data_out), .grant(grant), .busy(busy), .err_timeout(err_timeout),
    .sram_wr(sram_wr), .sram_rd(sram_rd), .sram_data_in(sram_data_in),
    .sram_offset(sram_offset), .sram_data_out(sram_data_out),
    .sram_read_finish(sram_read_finish), .sram_write_finish(sram_write_finish),
    .sram_available(sram_available)
  );

  // smart_ram model: answers LAT+1 cycles after wr/rd rises, once per access.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          auto_resp = 1'b1;
  logic          inj_rfin = 1'b0, inj_wfin = 1'b0;
  logic          m_rfin = 1'b0, m_wfin = 1'b0, m_done = 1'b0;
  logic [DW-1:0] m_dout = '0;
  int            m_cnt = 0;

  always @(posedge clk) begin
    m_rfin <= 1'b0;
    m_wfin <= 1'b0;
    if (!(sram_wr || sram_rd)) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (auto_resp && !m_done) begin
      if (m_cnt == LAT) begin
        m_done <= 1'b1;
        if (sram_wr) begin
          mem[sram_offset] <= sram_data_in;
          m_wfin <= 1'b1;
        end else begin
          m_dout <= mem[sram_offset];
          m_rfin <= 1'b1;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign sram_read_finish  = m_rfin | inj_rfin;
  assign sram_write_finish = m_wfin | inj_wfin;
  assign sram_data_out     = m_dout;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected finish pulses, popped when the DUT emits one.
  typedef struct {
    int          who;
    bit          wr;
    logic [15:0] data;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] exp_vec;
    if (!rst && ((|req_write_finish) || (|req_read_finish))) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_finish", {28'd0, req_write_finish, req_read_finish}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        exp_vec = e.wr ? {2'(1 << e.who), 2'b00} : {2'b00, 2'(1 << e.who)};
        chk("sb_finish_vec", {28'd0, req_write_finish, req_read_finish}, {28'd0, exp_vec});
        if (!e.wr) chk("sb_rdata", {16'd0, req_data_out}, {16'd0, e.data});
      end
    end
  end

  // One full transaction by a single requester with timing checks.
  task automatic do_txn(input int who, input bit wr, input bit rd,
                        input logic [AW-1:0] off, input logic [DW-1:0] data,
                        input logic [DW-1:0] exp_rd);
    exp_t e;
    bit   seen;
    e.who = who; e.wr = wr; e.data = exp_rd;
    sb_q.push_back(e);
    @(negedge clk);
    req_data[who*DW +: DW]   = data;
    req_offset[who*AW +: AW] = off;
    req_wr[who] = wr;
    req_rd[who] = rd;
    @(negedge clk);
    chk("txn_grant", {30'd0, grant}, 32'(1 << who));
    chk("txn_busy", {31'd0, busy}, 32'd1);
    chk("txn_sram_op", {30'd0, sram_wr, sram_rd}, wr ? 32'd2 : 32'd1);
    chk("txn_offset", {20'd0, sram_offset}, {20'd0, off});
    if (wr) chk("txn_wdata", {16'd0, sram_data_in}, {16'd0, data});
    // Requester inputs change mid-access; latched values must hold.
    req_data[who*DW +: DW]   = ~data;
    req_offset[who*AW +: AW] = ~off;
    @(negedge clk);
    chk("txn_offset_held", {20'd0, sram_offset}, {20'd0, off});
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (req_write_finish[who] || req_read_finish[who]) seen = 1'b1;
      else @(negedge clk);
    end
    chk("txn_finish_seen", {31'd0, seen}, 32'd1);
    chk("txn_release_grant", {30'd0, grant}, 32'(1 << who));
    chk("txn_release_op", {30'd0, sram_wr, sram_rd}, 32'd0);
    req_wr[who] = 1'b0;
    req_rd[who] = 1'b0;
    @(negedge clk);
    chk("txn_idle", {29'd0, busy, grant}, 32'd0);
  endtask

  typedef struct {
    int          who;
    bit          wr;
    bit          rd;
    logic [11:0] off;
    logic [15:0] data;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vecs[6];

  initial begin
    exp_t e;
    int nfin, gk, j;
    bit seen;
    logic [NR-1:0] prev_g;
    logic [1:0] gseq [4];

    vecs[0] = '{who: 0, wr: 1'b1, rd: 1'b0, off: 12'd0, data: 16'd142,   exp_rd: 16'd0};
    vecs[1] = '{who: 1, wr: 1'b0, rd: 1'b1, off: 12'd0, data: 16'd0,     exp_rd: 16'd142};
    vecs[2] = '{who: 0, wr: 1'b1, rd: 1'b0, off: 12'd0, data: 16'd2,     exp_rd: 16'd0};
    vecs[3] = '{who: 1, wr: 1'b1, rd: 1'b0, off: 12'd1, data: 16'd32,    exp_rd: 16'd0};
    vecs[4] = '{who: 0, wr: 1'b1, rd: 1'b1, off: 12'd7, data: 16'h1234,  exp_rd: 16'd0};
    vecs[5] = '{who: 1, wr: 1'b0, rd: 1'b1, off: 12'd7, data: 16'd0,     exp_rd: 16'h1234};
    gseq[0] = 2'b01; gseq[1] = 2'b10; gseq[2] = 2'b01; gseq[3] = 2'b10;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_outputs", {24'd0, grant, busy, err_timeout, sram_wr, sram_rd,
                        req_write_finish[0], req_read_finish[0]},
        32'd0);
    chk("rst_data", {sram_data_in, req_data_out}, 32'd0);
    rst = 1'b0;

    // Single transactions, including write+read treated as write.
    foreach (vecs[i])
      do_txn(vecs[i].who, vecs[i].wr, vecs[i].rd, vecs[i].off, vecs[i].data, vecs[i].exp_rd);

    // Both requesters reading continuously: grants alternate.
    for (int i = 0; i < 4; i++) begin
      e.who = i % 2; e.wr = 1'b0; e.data = (i % 2 == 0) ? 16'd2 : 16'd32;
      sb_q.push_back(e);
    end
    @(negedge clk);
    req_offset = {12'd1, 12'd0};
    req_rd = 2'b11;
    nfin = 0; gk = 0; prev_g = '0;
    for (int k = 0; k < 200 && nfin < 4; k++) begin
      @(negedge clk);
      if (grant != '0 && prev_g == '0) begin
        if (gk < 4) chk("rr_grant", {30'd0, grant}, {30'd0, gseq[gk]});
        gk++;
      end
      prev_g = grant;
      if (|req_read_finish) nfin++;
      if (nfin == 4) req_rd = 2'b00;
    end
    chk("rr_finish_count", 32'(nfin), 32'd4);
    repeat (2) @(negedge clk);

    // sram_available low blocks new grants.
    sram_available = 1'b0;
    e.who = 1; e.wr = 1'b1; e.data = 16'd0;
    sb_q.push_back(e);
    req_data[DW +: DW] = 16'h55AA;
    req_offset[AW +: AW] = 12'd9;
    req_wr[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("avail_blocked", {30'd0, grant}, 32'd0);
    sram_available = 1'b1;
    @(negedge clk);
    chk("avail_grant", {30'd0, grant}, 32'd2);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (req_write_finish[1]) seen = 1'b1;
    end
    chk("avail_finish_seen", {31'd0, seen}, 32'd1);
    req_wr[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Write finish during a read is ignored.
    auto_resp = 1'b0;
    e.who = 0; e.wr = 1'b0; e.data = 16'd32;
    sb_q.push_back(e);
    req_offset[0 +: AW] = 12'd1;
    req_rd[0] = 1'b1;
    @(negedge clk);
    chk("wrong_fin_grant", {30'd0, grant}, 32'd1);
    inj_wfin = 1'b1;
    @(negedge clk);
    inj_wfin = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrong_fin_access", {28'd0, busy, sram_rd, grant}, 32'b1101);
    auto_resp = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (req_read_finish[0]) seen = 1'b1;
    end
    chk("wrong_fin_read_done", {31'd0, seen}, 32'd1);
    req_rd[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ACCESS, then a late finish from smart_ram.
    auto_resp = 1'b0;
    req_rd[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_access_pre", {30'd0, grant}, 32'd2);
    rst = 1'b1;
    req_rd[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_access", {26'd0, grant, busy, sram_wr, sram_rd, |req_read_finish}, 32'd0);
    rst = 1'b0;
    inj_rfin = 1'b1;
    @(negedge clk);
    inj_rfin = 1'b0;
    @(negedge clk);
    chk("late_finish_ignored", {28'd0, grant, req_read_finish}, 32'd0);
    auto_resp = 1'b1;

    // Watchdog.
    auto_resp = 1'b0;
    req_offset[0 +: AW] = 12'd0;
    req_rd[0] = 1'b1;
    @(negedge clk);
    chk("wd_grant", {30'd0, grant}, 32'd1);
`ifdef SRAM_ARB_TIMEOUT_EN
    j = -1;
    for (int k = 1; k < 40 && j < 0; k++) begin
      @(negedge clk);
      if (err_timeout) j = k;
    end
    chk("wd_err_cycle", 32'(j), 32'(TO));
    req_rd[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("wd_back_idle", {29'd0, busy, grant}, 32'd0);
`else
    j = 0;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (err_timeout) j++;
    end
    chk("wd_no_err", 32'(j), 32'd0);
    chk("wd_still_access", {29'd0, busy, sram_rd, sram_wr}, 32'b110);
    rst = 1'b1;
    req_rd[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`endif
    auto_resp = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
